// File: rtl/md5_hasher.sv
// Iterative single-block MD5 engine: pads and length-encodes a short message in hardware,
// then runs UNROLL chained MD5 steps per clock until all 64 steps are done.
module md5_hasher #(
    parameter int MAX_BYTES = 8,
    parameter int UNROLL    = 1,
    localparam int LW       = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*MAX_BYTES-1:0] msg,
    input  logic [LW-1:0]          msg_len,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [127:0]           digest
);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Shift amounts indexed by {round, step mod 4}.
    localparam logic [4:0] S [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [3:0] msg_index(input logic [5:0] st);
        case (st[5:4])
            2'd0:    return st[3:0];
            2'd1:    return 4'(st * 6'd5 + 6'd1);
            2'd2:    return 4'(st * 6'd3 + 6'd5);
            default: return 4'(st * 6'd7);
        endcase
    endfunction

    // Returns the rotated state {a', b', c', d'} = {d, b + rotl(...), b, c}.
    function automatic logic [127:0] md5_step(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] d,
                                              input logic [5:0] st, input logic [31:0] m);
        logic [31:0] f;
        logic [31:0] t;
        case (st[5:4])
            2'd0:    f = (b & c) | (~b & d);
            2'd1:    f = (d & b) | (~d & c);
            2'd2:    f = b ^ c ^ d;
            default: f = c ^ (b | ~d);
        endcase
        t = a + f + K[st] + m;
        return {d, b + rotl(t, S[{st[5:4], st[1:0]}]), b, c};
    endfunction

    state_t                 state;
    logic [8*MAX_BYTES-1:0] msg_r;
    logic [LW-1:0]          len_r;
    logic [6:0]             step;
    logic [31:0]            a, b, c, d;
    logic [31:0]            w_r [16];

    logic [511:0]           msg_wide;
    logic [63:0]            bitlen;
    logic [7:0]             pad [64];
    logic [31:0]            blk [16];

    always_comb begin
        msg_wide = {msg_r, {(512 - 8*MAX_BYTES){1'b0}}};
        bitlen   = 64'(len_r) << 3;
        for (int k = 0; k < 56; k++) begin
            if (7'(k) < 7'(len_r))       pad[k] = msg_wide[511 - 8*k -: 8];
            else if (7'(k) == 7'(len_r)) pad[k] = 8'h80;
            else                         pad[k] = 8'h00;
        end
        for (int k = 56; k < 64; k++) begin
            pad[k] = bitlen[8*(k-56) +: 8];
        end
        for (int j = 0; j < 16; j++) begin
            blk[j] = {pad[4*j+3], pad[4*j+2], pad[4*j+1], pad[4*j]};
        end
    end

    logic [31:0]  na, nb, nc, nd;
    logic [5:0]   st;
    logic [127:0] nxt;

    always_comb begin
        na  = a;
        nb  = b;
        nc  = c;
        nd  = d;
        st  = step[5:0];
        nxt = '0;
        for (int u = 0; u < UNROLL; u++) begin
            st  = step[5:0] + 6'(u);
            nxt = md5_step(na, nb, nc, nd, st, w_r[msg_index(st)]);
            na  = nxt[127:96];
            nb  = nxt[95:64];
            nc  = nxt[63:32];
            nd  = nxt[31:0];
        end
    end

    always_ff @(posedge clk) begin
        done <= 1'b0;
        err  <= 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (msg_len > LW'(MAX_BYTES)) begin
                        err <= 1'b1;
                    end else begin
                        msg_r <= msg;
                        len_r <= msg_len;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
            end
            LOAD: begin
                w_r   <= blk;
                a     <= IV_A;
                b     <= IV_B;
                c     <= IV_C;
                d     <= IV_D;
                step  <= '0;
                state <= ROUND;
            end
            ROUND: begin
                a    <= na;
                b    <= nb;
                c    <= nc;
                d    <= nd;
                step <= step + 7'(UNROLL);
                if (step == 7'(64 - UNROLL)) state <= FINAL;
            end
            default: begin
                digest <= {bswap(IV_A + a), bswap(IV_B + b), bswap(IV_C + c), bswap(IV_D + d)};
                done   <= 1'b1;
                busy   <= 1'b0;
                state  <= IDLE;
            end
        endcase
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            digest <= '0;
            step   <= '0;
        end
    end

endmodule

// File: doc/md5_hasher.md
# md5_hasher

Iterative single-block MD5 engine, parametrised successor of the lab8 fixed 8-byte hasher. It accepts a message of 0..MAX_BYTES bytes with a start/done handshake and performs padding and length encoding in hardware. It runs UNROLL MD5 steps per clock and re-initialises the chaining state on every start, so it can hash back-to-back candidates. It sits between the password/candidate generator and the compare/display logic.

## Interface
- MAX_BYTES, 8, maximum message length in bytes; legal 1..55, so the message always fits one 512-bit block.
- UNROLL, 1, MD5 steps per ROUND cycle; legal 1, 2, 4.
- LW, $clog2(MAX_BYTES+1), width of msg_len (localparam).
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- msg  in  8*MAX_BYTES  message; byte 0 (first character) is msg[8*MAX_BYTES-1 -: 8], byte n is msg[8*(MAX_BYTES-n)-1 -: 8].
- msg_len  in  LW  message length in bytes; bytes at index >= msg_len are ignored.
- busy  out  1  high from the cycle after an accepted start through FINAL.
- done  out  1  one-cycle pulse; digest is valid from this cycle.
- err  out  1  one-cycle pulse when start is sampled with msg_len > MAX_BYTES.
- digest  out  128  MD5 value as a byte string, first byte in [127:120]: digest[127:120]=h0[7:0] … digest[7:0]=h3[31:24].

## Operation
- States: IDLE, LOAD, ROUND, FINAL.
- IDLE: on start with msg_len <= MAX_BYTES, register msg and msg_len, then go to LOAD. On start with msg_len > MAX_BYTES, pulse err next cycle, stay in IDLE, leave digest unchanged.
- LOAD: build the 16-word block from the registered copy.
  - Byte i (0..63) = msg byte i for i < msg_len; 0x80 for i == msg_len; 0x00 otherwise.
  - Bytes 56..63 = msg_len*8 as a 64-bit little-endian value.
  - w[j] = {byte 4j+3, byte 4j+2, byte 4j+1, byte 4j}.
  - a,b,c,d = 67452301, efcdab89, 98badcfe, 10325476; step counter i = 0.
- ROUND: each cycle applies UNROLL chained standard MD5 steps i..i+UNROLL-1, then i += UNROLL.
  - Function F/G/H/I, index g (i, 5i+1, 3i+5, 7i mod 16), shift r[i] and constant K[i] per RFC 1321.
  - All arithmetic is mod 2^32. Rotate left, never a shift.
  - Leave ROUND after the cycle performing step 63.
- FINAL: h0..h3 = initial constants + a,b,c,d. Register digest with byte reordering, assert done for one cycle, return to IDLE.
- msg/msg_len changes while busy have no effect. start while busy is ignored, not queued.
- digest holds its value until the next successful FINAL.

## Timing
- Reset values: busy=0, done=0, err=0, digest=128'h0, state IDLE, i=0.
- With start high at cycle 0 (accepted): LOAD at cycle 1, ROUND cycles 2..1+64/UNROLL, FINAL at 2+64/UNROLL.
- done and the new digest are visible at cycle 3+64/UNROLL: 67 for UNROLL=1, 35 for 2, 19 for 4.
- busy is high cycles 1..2+64/UNROLL and low in the done cycle.
- A new start may be asserted in the done cycle (state is IDLE) and is accepted. Throughput is one hash per 3+64/UNROLL cycles.
- err is visible at cycle 1. busy stays 0.
- Reset mid-operation: next cycle all outputs take reset values and no done follows. A start after reset release is accepted normally.
- msg_len == MAX_BYTES and msg_len == 0 are legal. 0x80 lands at byte msg_len in both cases.

## Test plan
- msg_len=0 -> done at cycle 67 (UNROLL=1), digest=d41d8cd98f00b204e9800998ecf8427e.
- "abc" (msg_len=3, MAX_BYTES=8, trailing bytes 0xFF to prove masking) -> 900150983cd24fb0d6963f7d28e17f72.
- "password" then "12345678" back-to-back, second start in the first done cycle -> 5f4dcc3b5aa765d61d8327deb882cf99, then 25d55ad283aa400af464c76d713c07ad, with no state carry-over.
- UNROLL=2 and UNROLL=4 builds, "a" -> 0cc175b9c0f1b6a831c399e269772661 at cycle 35 and 19 respectively.
- msg_len=9 with MAX_BYTES=8 -> err pulse at cycle 1, busy stays 0, digest unchanged. Separately, start pulsed at cycle 10 during a hash -> ignored, and only one done occurs.
- reset_n low at cycle 30 of a hash -> busy/done/digest zero next cycle and no done. Rehash of "abc" after release gives the correct digest.
